// File: rtl/psum_accumulate_writeback_pkg.sv
// Shared control-bit positions, FSM encoding and write-enable constant for the
// psum accumulate/writeback path.
package psum_accumulate_writeback_pkg;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_RELU_BIT = 4;

    // Wide enough for any byte-enable width; users slice the low NUM_BYTE bits.
    localparam logic [63:0] WREN_ALL = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/psum_addr_pass_counter.sv
// Output-index / pass counter: walks 0..last_addr once per pass and flags the
// final element of the final pass.
module psum_addr_pass_counter #(
    parameter int ADDR_WIDTH = 32,
    parameter int PASS_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic [PASS_WIDTH-1:0] last_pass,
    output logic [ADDR_WIDTH-1:0] addr_cnt,
    output logic [PASS_WIDTH-1:0] pass_cnt,
    output logic                  last_elem
);

    logic addr_wrap;

    assign addr_wrap = (addr_cnt == last_addr);
    assign last_elem = addr_wrap && (pass_cnt == last_pass);

    // pass_cnt holds at the final pass so it keeps reporting a valid index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_cnt <= '0;
            pass_cnt <= '0;
        end else if (clear) begin
            addr_cnt <= '0;
            pass_cnt <= '0;
        end else if (step) begin
            if (addr_wrap) begin
                addr_cnt <= '0;
                if (!last_elem)
                    pass_cnt <= pass_cnt + 1'b1;
            end else begin
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/psum_accumulate_writeback.sv
// Read-modify-write accumulation of the PE-array psum stream into the psum
// BRAM across channel-group passes, with optional ReLU on the last pass.
module psum_accumulate_writeback
    import psum_accumulate_writeback_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_BYTE   = 4,
    parameter int REG_WIDTH  = 32,
    parameter int PASS_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
    input  logic [REG_WIDTH-1:0]  i_conf_outputsize,
    input  logic [PASS_WIDTH-1:0] i_conf_numpass,
    input  logic [DATA_WIDTH-1:0] i_psum_data,
    input  logic                  i_psum_valid,
    output logic                  o_psum_ready,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdat,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdat,
    output logic [NUM_BYTE-1:0]   mem_wren,
    output logic                  mem_enb,
    output logic [PASS_WIDTH-1:0] o_pass_cnt,
    output logic                  o_done
);

    state_t state, state_nxt;
    logic en_q, relu_q, fin_acc;
    logic [ADDR_WIDTH-1:0] osize_q;
    logic [PASS_WIDTH-1:0] npass_q;
    logic start, abort, accept, last_elem;
    logic [ADDR_WIDTH-1:0] addr_cnt, raddr_q;
    logic [PASS_WIDTH-1:0] pass_cnt;
    logic [1:0] vld_pipe;
    logic [ADDR_WIDTH-1:0] s1_addr, waddr_q, pwaddr;
    logic [DATA_WIDTH-1:0] s1_psum, wdat_q, pwdat, prev, sum, wr_data;
    logic s1_first, s1_last, pwr;
    logic cfg_unused;

    assign cfg_unused = ^{i_conf_ctrl, i_conf_outputsize};

    assign start        = (state == ST_IDLE) && i_conf_ctrl[CTRL_EN_BIT] && !en_q;
    assign abort        = (state == ST_RUN) && !i_conf_ctrl[CTRL_EN_BIT];
    assign o_psum_ready = (state == ST_RUN) && !fin_acc;
    assign accept       = i_psum_valid && o_psum_ready;
    assign o_done       = (state == ST_DONE);
    assign o_pass_cnt   = pass_cnt;

    psum_addr_pass_counter #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .PASS_WIDTH(PASS_WIDTH)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (start),
        .step     (accept),
        .last_addr(osize_q),
        .last_pass(npass_q),
        .addr_cnt (addr_cnt),
        .pass_cnt (pass_cnt),
        .last_elem(last_elem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort)                        state_nxt = ST_IDLE;
                else if (fin_acc && !vld_pipe[0]) state_nxt = ST_DONE;
            end
            ST_DONE: if (!i_conf_ctrl[CTRL_EN_BIT]) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q    <= 1'b0;
            relu_q  <= 1'b0;
            fin_acc <= 1'b0;
            osize_q <= '0;
            npass_q <= '0;
        end else begin
            en_q <= i_conf_ctrl[CTRL_EN_BIT];
            if (start) begin
                osize_q <= i_conf_outputsize[ADDR_WIDTH-1:0];
                npass_q <= i_conf_numpass;
                relu_q  <= i_conf_ctrl[CTRL_RELU_BIT];
                fin_acc <= 1'b0;
            end else if (accept && last_elem) begin
                fin_acc <= 1'b1;
            end
        end
    end

    // Forward from the write on the port now, then from last cycle's write,
    // which the BRAM read issued alongside it could not yet observe.
    always_comb begin
        prev = mem_rdat;
        if (vld_pipe[1] && (waddr_q == s1_addr))
            prev = wdat_q;
        else if (pwr && (pwaddr == s1_addr))
            prev = pwdat;
        sum     = s1_first ? s1_psum : (s1_psum + prev);
        wr_data = (s1_last && relu_q && sum[DATA_WIDTH-1]) ? '0 : sum;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            raddr_q  <= '0;
            s1_addr  <= '0;
            s1_psum  <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            waddr_q  <= '0;
            wdat_q   <= '0;
            pwr      <= 1'b0;
            pwaddr   <= '0;
            pwdat    <= '0;
        end else begin
            vld_pipe <= abort ? 2'b00 : {vld_pipe[0], accept};
            if (accept) begin
                raddr_q  <= addr_cnt;
                s1_addr  <= addr_cnt;
                s1_psum  <= i_psum_data;
                s1_first <= (pass_cnt == '0);
                s1_last  <= (pass_cnt == npass_q);
            end
            if (vld_pipe[0]) begin
                waddr_q <= s1_addr;
                wdat_q  <= wr_data;
            end
            pwr    <= vld_pipe[1];
            pwaddr <= waddr_q;
            pwdat  <= wdat_q;
        end
    end

    assign mem_raddr = accept ? addr_cnt : raddr_q;
    assign mem_waddr = waddr_q;
    assign mem_wdat  = wdat_q;
    assign mem_enb   = vld_pipe[1];
    assign mem_wren  = vld_pipe[1] ? WREN_ALL[NUM_BYTE-1:0] : '0;

endmodule

// File: tb/tb_psum_accumulate_writeback.sv
// Randomized bench: psum jobs scored against a per-address accumulation model
// and a behavioural BRAM with one-cycle read latency.
module tb_psum_accumulate_writeback;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NB = 4;
    localparam int RW = 32;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] i_conf_ctrl, i_conf_outputsize;
    logic [PW-1:0] i_conf_numpass;
    logic [DW-1:0] i_psum_data;
    logic          i_psum_valid;
    logic          o_psum_ready;
    logic [AW-1:0] mem_raddr, mem_waddr;
    logic [DW-1:0] mem_rdat, mem_wdat;
    logic [NB-1:0] mem_wren;
    logic          mem_enb;
    logic [PW-1:0] o_pass_cnt;
    logic          o_done;

    always #5 clk = ~clk;

    psum_accumulate_writeback #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BYTE(NB), .REG_WIDTH(RW), .PASS_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_conf_ctrl(i_conf_ctrl), .i_conf_outputsize(i_conf_outputsize),
        .i_conf_numpass(i_conf_numpass),
        .i_psum_data(i_psum_data), .i_psum_valid(i_psum_valid), .o_psum_ready(o_psum_ready),
        .mem_raddr(mem_raddr), .mem_rdat(mem_rdat),
        .mem_waddr(mem_waddr), .mem_wdat(mem_wdat), .mem_wren(mem_wren), .mem_enb(mem_enb),
        .o_pass_cnt(o_pass_cnt), .o_done(o_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // BRAM model: read-before-write, garbage prefill so pass-0 reads are poisoned
    logic [DW-1:0] mem [0:63];
    logic          prefill = 1'b0;
    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < 64; i++) mem[i] <= $urandom;
        end else if (mem_enb && mem_wren == {NB{1'b1}}) begin
            mem[mem_waddr[5:0]] <= mem_wdat;
        end
        mem_rdat <= mem[mem_raddr[5:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] exp_raddr[$];
    logic [PW-1:0] exp_pass[$];
    logic [AW-1:0] exp_waddr[$];
    logic [DW-1:0] exp_wdat[$];
    int            acc_cyc[$];
    int            wr_count = 0;
    int            last_wr_cyc = 0;
    logic [DW-1:0] job_ps[$];

    always @(negedge clk) begin
        if (rst) begin
            if (i_psum_valid && o_psum_ready) begin
                if (exp_raddr.size() == 0) chk("extra_accept", 1, 0);
                else begin
                    chk("raddr", mem_raddr, exp_raddr.pop_front());
                    chk("pass_cnt", o_pass_cnt, exp_pass.pop_front());
                end
                acc_cyc.push_back(cyc);
            end
            if (mem_enb) begin
                wr_count++;
                last_wr_cyc = cyc;
                chk("wren", mem_wren, {NB{1'b1}});
                if (exp_waddr.size() == 0 || acc_cyc.size() == 0) chk("extra_write", 1, 0);
                else begin
                    chk("waddr", mem_waddr, exp_waddr.pop_front());
                    chk("wdat", mem_wdat, exp_wdat.pop_front());
                    chk("latency", cyc - acc_cyc.pop_front(), 2);
                end
            end else begin
                chk("wren_idle", mem_wren, 0);
            end
        end
    end

    task automatic clear_sb();
        exp_raddr.delete(); exp_pass.delete();
        exp_waddr.delete(); exp_wdat.delete(); acc_cyc.delete();
    endtask

    // stop_at >= 0: after that many accepts, abort (use_rst=0) or reset (use_rst=1)
    task automatic run_job(input int os, input int np, input bit relu, input bit gaps,
                           input int stop_at, input bit use_rst);
        logic [DW-1:0] acc [0:63];
        int n, idx, budget, wc0;
        n = (os + 1) * (np + 1);
        for (int p = 0; p <= np; p++) begin
            for (int a = 0; a <= os; a++) begin
                if (p == 0) acc[a] = job_ps[p*(os+1)+a];
                else        acc[a] = acc[a] + job_ps[p*(os+1)+a];
                if (p == np && relu && $signed(acc[a]) < 0) acc[a] = '0;
                exp_raddr.push_back(AW'(a));
                exp_pass.push_back(PW'(p));
                exp_waddr.push_back(AW'(a));
                exp_wdat.push_back(acc[a]);
            end
        end
        @(posedge clk); #1 prefill = 1'b1;
        @(posedge clk); #1 prefill = 1'b0;
        wc0 = wr_count;
        i_conf_outputsize = RW'(os);
        i_conf_numpass    = PW'(np);
        i_conf_ctrl       = '0;
        i_conf_ctrl[4]    = relu;
        i_conf_ctrl[0]    = 1'b1;
        idx = 0;
        budget = 0;
        while (idx < n && budget < 2000) begin
            @(posedge clk); #1;
            if (budget == 2) begin
                i_conf_outputsize = $urandom;
                i_conf_numpass    = PW'($urandom);
            end
            if (stop_at >= 0 && idx == stop_at) begin
                i_psum_valid = 1'b0;
                if (use_rst) begin
                    #1 rst = 1'b0;
                    #1;
                    chk("rst_enb", mem_enb, 0);
                    chk("rst_wren", mem_wren, 0);
                    chk("rst_waddr", mem_waddr, 0);
                    chk("rst_wdat", mem_wdat, 0);
                    chk("rst_raddr", mem_raddr, 0);
                    chk("rst_ready", o_psum_ready, 0);
                    chk("rst_done", o_done, 0);
                    chk("rst_pass", o_pass_cnt, 0);
                    clear_sb();
                    i_conf_ctrl = '0;
                    @(posedge clk); #1 rst = 1'b1;
                end else begin
                    i_conf_ctrl[0] = 1'b0;
                    repeat (6) @(posedge clk);
                    #1;
                    chk("abort_writes", wr_count - wc0, idx - 1);
                    chk("abort_ready", o_psum_ready, 0);
                    chk("abort_done", o_done, 0);
                    clear_sb();
                end
                return;
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                i_psum_valid = 1'b0;
                i_psum_data  = $urandom;
            end else begin
                i_psum_valid = 1'b1;
                i_psum_data  = job_ps[idx];
            end
            #1;
            if (i_psum_valid && o_psum_ready) idx++;
            budget++;
        end
        chk("accept_budget", idx, n);
        @(posedge clk); #1 i_psum_valid = 1'b0;
        budget = 0;
        while (!o_done && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        chk("done", o_done, 1);
        chk("done_lat", cyc - last_wr_cyc, 1);
        chk("ready_in_done", o_psum_ready, 0);
        chk("writes", wr_count - wc0, n);
        chk("sb_empty", exp_waddr.size(), 0);
        for (int a = 0; a <= os; a++) chk("mem_final", mem[a], acc[a]);
        @(posedge clk); #1 i_conf_ctrl[0] = 1'b0;
        @(posedge clk); #1;
        chk("done_clear", o_done, 0);
        clear_sb();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        i_conf_ctrl = '0;
        i_conf_outputsize = '0;
        i_conf_numpass = '0;
        i_psum_data = '0;
        i_psum_valid = 1'b0;
        #1;
        chk("reset_enb", mem_enb, 0);
        chk("reset_wren", mem_wren, 0);
        chk("reset_raddr", mem_raddr, 0);
        chk("reset_waddr", mem_waddr, 0);
        chk("reset_ready", o_psum_ready, 0);
        chk("reset_done", o_done, 0);
        chk("reset_pass", o_pass_cnt, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        job_ps = '{32'd5, 32'd6, 32'd7, 32'd8};
        run_job(3, 0, 1'b0, 1'b0, -1, 1'b0);

        job_ps.delete();
        for (int i = 0; i < 12; i++) job_ps.push_back(32'd1);
        run_job(3, 2, 1'b0, 1'b0, -1, 1'b0);
        for (int a = 0; a < 4; a++) chk("ones_x3", mem[a], 32'd3);

        job_ps = '{32'd10, 32'd20, 32'd30, 32'd40};
        run_job(0, 3, 1'b0, 1'b0, -1, 1'b0);
        chk("fwd_total", mem[0], 32'd100);

        job_ps = '{32'hFFFF_FFFB, 32'd2};
        run_job(0, 1, 1'b1, 1'b0, -1, 1'b0);
        chk("relu_on", mem[0], 32'd0);

        job_ps = '{32'hFFFF_FFFB, 32'd2};
        run_job(0, 1, 1'b0, 1'b0, -1, 1'b0);
        chk("relu_off", mem[0], 32'hFFFF_FFFD);

        job_ps = '{32'h7FFF_FFFF, 32'd1};
        run_job(0, 1, 1'b0, 1'b0, -1, 1'b0);
        chk("overflow", mem[0], 32'h8000_0000);

        job_ps.delete();
        for (int i = 0; i < 8; i++) job_ps.push_back($urandom);
        run_job(1, 3, 1'b0, 1'b0, -1, 1'b0);

        for (int j = 0; j < 6; j++) begin
            int os, np;
            bit relu;
            os = $urandom_range(0, 5);
            np = $urandom_range(0, 3);
            relu = 1'($urandom_range(0, 1));
            job_ps.delete();
            for (int i = 0; i < (os + 1) * (np + 1); i++) begin
                if (j[0]) job_ps.push_back($urandom);
                else      job_ps.push_back(DW'($urandom_range(0, 200)) - 32'd100);
            end
            run_job(os, np, relu, 1'b1, -1, 1'b0);
        end

        job_ps.delete();
        for (int i = 0; i < 16; i++) job_ps.push_back($urandom_range(1, 50));
        run_job(7, 1, 1'b0, 1'b0, 5, 1'b0);

        job_ps.delete();
        for (int i = 0; i < 8; i++) job_ps.push_back($urandom_range(1, 50));
        run_job(1, 3, 1'b0, 1'b0, 5, 1'b1);

        job_ps = '{32'd9, 32'd4};
        run_job(1, 0, 1'b0, 1'b0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
